// File: rtl/sound_mixer_tdm.sv
// Time-multiplexed stereo mixer: CH channels with runtime gain and L/R pan,
// one shared multiplier, saturating output and sticky clip/overrun flags.
module sound_mixer_tdm #(
    parameter int CH  = 4,
    parameter int IW  = 16,
    parameter int GW  = 8,
    parameter int GSH = 4,
    parameter int OW  = 16
) (
    input  logic             i_EMU_MCLK,
    input  logic             i_EMU_RST,
    input  logic             i_SAMPLE_STB,
    input  logic [CH*IW-1:0] i_CH_DATA,
    input  logic [CH*GW-1:0] i_GAIN,
    input  logic [CH-1:0]    i_PAN_L,
    input  logic [CH-1:0]    i_PAN_R,
    input  logic             i_FLAG_CLR,
    output logic [OW-1:0]    o_SND_L,
    output logic [OW-1:0]    o_SND_R,
    output logic             o_VALID,
    output logic             o_BUSY,
    output logic             o_CLIP_L,
    output logic             o_CLIP_R,
    output logic             o_OVERRUN
);
    localparam int PW = IW + GW + 1;
    localparam int AW = PW + $clog2(CH);
    localparam int KW = (CH > 1) ? $clog2(CH) : 1;
    localparam logic signed [AW-1:0] SMAX = {{(AW-OW+1){1'b0}}, {(OW-1){1'b1}}};
    localparam logic signed [AW-1:0] SMIN = {{(AW-OW+1){1'b1}}, {(OW-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_MAC, S_OUT} state_t;
    state_t state, state_nx;

    logic [CH*IW-1:0]       data_q;
    logic [CH*GW-1:0]       gain_q;
    logic [CH-1:0]          pan_l_q, pan_r_q;
    logic [KW-1:0]          k;
    logic signed [AW-1:0]   acc_l, acc_r;
    logic signed [PW-1:0]   da, ga, prod;
    logic signed [AW-1:0]   prod_ext;
    logic [OW:0]            sat_l, sat_r;
    logic                   last;

    // Result is {clip, sample}; floor shift then clamp to the OW-bit range.
    function automatic logic [OW:0] sat_shift(input logic signed [AW-1:0] acc);
        logic signed [AW-1:0] s;
        s = acc >>> GSH;
        if (s > SMAX)      return {1'b1, SMAX[OW-1:0]};
        else if (s < SMIN) return {1'b1, SMIN[OW-1:0]};
        else               return {1'b0, s[OW-1:0]};
    endfunction

    // Shared multiplier: signed sample times zero-extended gain.
    assign da       = PW'($signed(data_q[k*IW +: IW]));
    assign ga       = $signed({1'b0, gain_q[k*GW +: GW]});
    assign prod     = da * ga;
    assign prod_ext = AW'(prod);
    assign sat_l    = sat_shift(acc_l);
    assign sat_r    = sat_shift(acc_r);
    assign last     = (k == KW'(CH - 1));
    assign o_BUSY   = (state != S_IDLE);

    always_ff @(posedge i_EMU_MCLK) begin
        if (i_EMU_RST) state <= S_IDLE;
        else           state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (i_SAMPLE_STB) state_nx = S_MAC;
            S_MAC:   if (last) state_nx = S_OUT;
            S_OUT:   state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge i_EMU_MCLK) begin
        if (i_EMU_RST) begin
            data_q    <= '0;
            gain_q    <= '0;
            pan_l_q   <= '0;
            pan_r_q   <= '0;
            k         <= '0;
            acc_l     <= '0;
            acc_r     <= '0;
            o_SND_L   <= '0;
            o_SND_R   <= '0;
            o_VALID   <= 1'b0;
            o_CLIP_L  <= 1'b0;
            o_CLIP_R  <= 1'b0;
            o_OVERRUN <= 1'b0;
        end else begin
            o_VALID <= 1'b0;
            case (state)
                S_IDLE: if (i_SAMPLE_STB) begin
                    data_q  <= i_CH_DATA;
                    gain_q  <= i_GAIN;
                    pan_l_q <= i_PAN_L;
                    pan_r_q <= i_PAN_R;
                    acc_l   <= '0;
                    acc_r   <= '0;
                    k       <= '0;
                end
                S_MAC: begin
                    if (pan_l_q[k]) acc_l <= acc_l + prod_ext;
                    if (pan_r_q[k]) acc_r <= acc_r + prod_ext;
                    if (!last) k <= k + 1'b1;
                end
                S_OUT: begin
                    o_SND_L <= sat_l[OW-1:0];
                    o_SND_R <= sat_r[OW-1:0];
                    o_VALID <= 1'b1;
                end
                default: ;
            endcase
            // Set beats clear when both land on the same edge.
            if (state == S_OUT && sat_l[OW])           o_CLIP_L <= 1'b1;
            else if (i_FLAG_CLR)                       o_CLIP_L <= 1'b0;
            if (state == S_OUT && sat_r[OW])           o_CLIP_R <= 1'b1;
            else if (i_FLAG_CLR)                       o_CLIP_R <= 1'b0;
            if (i_SAMPLE_STB && state != S_IDLE)       o_OVERRUN <= 1'b1;
            else if (i_FLAG_CLR)                       o_OVERRUN <= 1'b0;
        end
    end
endmodule

// File: tb/tb_sound_mixer_tdm.sv
// Randomized bench for sound_mixer_tdm against a longint arithmetic mix model.
module tb_sound_mixer_tdm;
    localparam int CH = 4, IW = 16, GW = 8, GSH = 4, OW = 16;

    logic             clk = 1'b0, rst = 1'b1, stb = 1'b0, clr = 1'b0;
    logic [CH*IW-1:0] ch_data = '0;
    logic [CH*GW-1:0] gain = '0;
    logic [CH-1:0]    pan_l = '0, pan_r = '0;
    logic [OW-1:0]    snd_l, snd_r;
    logic             valid, busy, clip_l, clip_r, ovr;

    sound_mixer_tdm #(.CH(CH), .IW(IW), .GW(GW), .GSH(GSH), .OW(OW)) dut (
        .i_EMU_MCLK(clk), .i_EMU_RST(rst), .i_SAMPLE_STB(stb),
        .i_CH_DATA(ch_data), .i_GAIN(gain), .i_PAN_L(pan_l), .i_PAN_R(pan_r),
        .i_FLAG_CLR(clr), .o_SND_L(snd_l), .o_SND_R(snd_r), .o_VALID(valid),
        .o_BUSY(busy), .o_CLIP_L(clip_l), .o_CLIP_R(clip_r), .o_OVERRUN(ovr)
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_bad = 0;
    logic signed [IW-1:0] d[CH];
    logic [GW-1:0]        g[CH];
    bit ecl = 0, ecr = 0, eov = 0;

    task automatic chk(input string tag, input longint got, input longint exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic load();
        for (int k = 0; k < CH; k++) begin
            ch_data[k*IW +: IW] = d[k];
            gain[k*GW +: GW]    = g[k];
        end
    endtask

    function automatic void model(output longint l, output longint r,
                                  output bit cl, output bit cr);
        longint sl = 0, sr = 0, p;
        longint mx = (longint'(1) << (OW - 1)) - 1;
        longint mn = -mx - 1;
        for (int k = 0; k < CH; k++) begin
            p = longint'(d[k]) * longint'(g[k]);
            if (pan_l[k]) sl += p;
            if (pan_r[k]) sr += p;
        end
        sl = sl >>> GSH;
        sr = sr >>> GSH;
        cl = (sl > mx) || (sl < mn);
        cr = (sr > mx) || (sr < mn);
        l  = (sl > mx) ? mx : ((sl < mn) ? mn : sl);
        r  = (sr > mx) ? mx : ((sr < mn) ? mn : sr);
    endfunction

    // Strobe one sample from the current d/g/pan; optionally pulse clear on the
    // output edge, or re-strobe with ch0=5000 while still mixing.
    task automatic mix(input string tag, input bit clr_at_out, input int ovr_at);
        longint el, er;
        bit cl, cr;
        int cyc, bcnt;
        load();
        model(el, er, cl, cr);
        stb = 1'b1;
        @(posedge clk); #1;
        stb = 1'b0;
        chk({tag, "/valid_low"}, valid, 0);
        cyc = 0; bcnt = 0;
        while (!valid && cyc < 20) begin
            if (busy) bcnt++;
            if (cyc == ovr_at) begin d[0] = 5000; load(); stb = 1'b1; end
            if (cyc == ovr_at + 1) stb = 1'b0;
            if (cyc == CH) clr = clr_at_out;
            @(posedge clk); #1;
            cyc++;
        end
        clr = 1'b0;
        stb = 1'b0;
        ecl = cl | (ecl & !clr_at_out);
        ecr = cr | (ecr & !clr_at_out);
        eov = (ovr_at >= 0) | (eov & !clr_at_out);
        chk({tag, "/latency"}, cyc, CH + 1);
        chk({tag, "/busy_cycles"}, bcnt, CH + 1);
        chk({tag, "/L"}, $signed(snd_l), el);
        chk({tag, "/R"}, $signed(snd_r), er);
        chk({tag, "/clip_l"}, clip_l, ecl);
        chk({tag, "/clip_r"}, clip_r, ecr);
        chk({tag, "/overrun"}, ovr, eov);
        chk({tag, "/busy_done"}, busy, 0);
    endtask

    task automatic set_ch(input int k, input int dv, input int gv, input bit l, input bit r);
        d[k] = IW'(dv); g[k] = GW'(gv); pan_l[k] = l; pan_r[k] = r;
    endtask

    task automatic clear_all();
        for (int k = 0; k < CH; k++) set_ch(k, 0, 0, 0, 0);
    endtask

    initial begin
        int nv;
        clear_all();
        load();
        repeat (2) @(posedge clk);
        #1;
        chk("rst/L", snd_l, 0);
        chk("rst/R", snd_r, 0);
        chk("rst/valid", valid, 0);
        chk("rst/busy", busy, 0);
        chk("rst/flags", {clip_l, clip_r, ovr}, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        set_ch(0, 1000, 16, 1, 0);
        mix("single", 0, -1);

        set_ch(0, 1000, 16, 1, 1);
        set_ch(1, -500, 32, 1, 1);
        set_ch(2, 300, 8, 0, 1);
        set_ch(3, -7, 1, 1, 0);
        mix("floor", 0, -1);

        clear_all();
        set_ch(0, 32767, 255, 1, 0);
        set_ch(1, 32767, 255, 1, 0);
        mix("sat_pos", 0, -1);
        clear_all();
        set_ch(0, -32768, 255, 0, 1);
        mix("sat_neg", 0, -1);

        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        ecl = 0; ecr = 0; eov = 0;
        chk("clr/clip_l", clip_l, 0);
        chk("clr/clip_r", clip_r, 0);

        clear_all();
        set_ch(0, 32767, 255, 1, 0);
        set_ch(1, 32767, 255, 1, 0);
        mix("sat_same_edge_clr", 1, -1);

        clear_all();
        set_ch(0, 1000, 16, 1, 0);
        mix("snapshot", 0, 1);
        nv = 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (valid) nv++;
        end
        chk("snapshot/extra_valid", nv, 0);
        mix("after_overrun", 0, -1);

        // Reset two edges into a sample: nothing comes out, everything zeroed.
        set_ch(1, 1234, 40, 0, 1);
        load();
        stb = 1'b1;
        @(posedge clk); #1;
        stb = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        ecl = 0; ecr = 0; eov = 0;
        chk("midrst/L", snd_l, 0);
        chk("midrst/R", snd_r, 0);
        chk("midrst/busy", busy, 0);
        chk("midrst/flags", {clip_l, clip_r, ovr}, 0);
        nv = 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (valid) nv++;
        end
        chk("midrst/no_valid", nv, 0);
        mix("after_rst", 0, -1);

        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        ecl = 0; ecr = 0; eov = 0;
        for (int s = 0; s < 10; s++) begin
            for (int k = 0; k < CH; k++)
                set_ch(k, int'($urandom_range(0, 65535)) - 32768,
                       int'($urandom_range(0, 255)), 1'($urandom), 1'($urandom));
            mix($sformatf("b2b%0d", s), 0, -1);
        end

        for (int s = 0; s < 20; s++) begin
            for (int k = 0; k < CH; k++)
                set_ch(k, int'($urandom_range(0, 2047)) - 1024,
                       int'($urandom_range(0, 64)), 1'($urandom), 1'($urandom));
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            mix($sformatf("rnd%0d", s), 0, -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
